operand_select_pipe: RTL
========================

OPERAND_SELECT_PIPE -- requirements
Module: operand_select_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter NUM_SRC, default 4, number of source registers (2..16).
REQ-003 Derived localparam SEL_W = $clog2(NUM_SRC); not overridable.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 src_data  input  NUM_SRC*WIDTH  flattened sources; source i at bits [i*WIDTH +: WIDTH].
REQ-007 select  input  SEL_W  source index used in direct mode.
REQ-008 mode  input  1  0 = direct, 1 = scan.
REQ-009 in_valid  input  1  request to capture one operand this cycle.
REQ-010 in_ready  output  1  block can accept a capture this cycle.
REQ-011 out_operand  output  WIDTH  registered selected operand.
REQ-012 out_src  output  SEL_W  index of the source captured into out_operand.
REQ-013 out_err  output  1  captured index was out of range (>= NUM_SRC).
REQ-014 out_valid  output  1  out_operand/out_src/out_err are valid.
REQ-015 out_ready  input  1  consumer accepts the output this cycle.

Function
REQ-016 Capture SHALL occur on a rising edge where in_valid && in_ready.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 Latency: captured data SHALL appear on out_* the cycle after capture; throughput one operand per cycle.
REQ-019 Direct mode: captured index SHALL be select, sampled at the capture edge.
REQ-020 Scan mode: captured index SHALL be the scan counter value.
REQ-021 Scan counter SHALL increment by one per capture in scan mode and wrap NUM_SRC-1 -> 0.
REQ-022 Scan counter SHALL be held at 0 while mode = 0, so each entry into scan mode starts at source 0.
REQ-023 Index >= NUM_SRC (possible only if NUM_SRC is not a power of two) SHALL capture out_operand = 0 and out_err = 1; otherwise out_err = 0.
REQ-024 out_valid SHALL set on capture, and clear on an edge with out_valid && out_ready && no capture.
REQ-025 Simultaneous drain and capture SHALL keep out_valid = 1 and load the new data; no bubble.
REQ-026 While out_valid && !out_ready, out_operand, out_src, out_err SHALL hold stable and no capture SHALL occur, regardless of src_data, select or mode changes.
REQ-027 A mode change during a stall SHALL take effect on the next capture only.
REQ-028 in_valid = 0 SHALL neither advance the scan counter nor change out_*.

Reset
REQ-029 On rst_n = 0, immediately and asynchronously: out_valid = 0, out_operand = 0, out_src = 0, out_err = 0, scan counter = 0.
REQ-030 Reset mid-stall SHALL discard the held operand; no capture on the first edge after rst_n rises unless in_valid = 1.
REQ-031 Reset deassertion is assumed synchronised externally; the block adds no synchroniser.

Structure
REQ-032 Shared package SHALL hold mode encodings (MODE_DIRECT = 0, MODE_SCAN = 1) and default WIDTH/NUM_SRC constants.
REQ-033 Scan counter SHALL be a sub-module src_scan_counter (params NUM_SRC; ports clk, rst_n, clear, advance, count).
REQ-034 The selection mux SHALL be combinational feeding the single output register stage; no other pipeline stages.

Verification
REQ-035 Direct: sources 0x11,0x22,0x33,0x44, out_ready=1, select 2 with in_valid -> next cycle out_operand 0x33, out_src 2, out_valid 1.
REQ-036 Scan: mode=1, in_valid held 6 cycles, out_ready=1 -> out_src sequence 0,1,2,3,0,1, operands to match.
REQ-037 Stall: out_ready=0 for 3 cycles after one capture, change select/src_data -> out_* unchanged, in_ready 0; out_ready=1 -> next capture lands, no loss or duplicate.
REQ-038 NUM_SRC=3, direct, select 3 -> out_operand 0, out_err 1; select 1 -> out_err 0.
REQ-039 Reset mid-stall: rst_n low between edges -> out_valid 0 immediately; after release, scan mode first out_src 0.
REQ-040 WIDTH=16, NUM_SRC=8 random back-to-back stream vs. scoreboard -> every capture observed once, in order.

Source files
------------

// File: rtl/operand_select_pipe_pkg.sv
// Shared definitions for the operand select pipeline.
// Contents: the mode encoding and the default operand width and source count.
package operand_select_pipe_pkg;

  // Operating mode: direct uses the select input, scan walks the sources in order.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_WIDTH   = 8;
  localparam int unsigned DEFAULT_NUM_SRC = 4;

endpackage

// File: rtl/src_scan_counter.sv
// Source scan counter: steps through source indices 0..NUM_SRC-1 and wraps to 0.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - forces the count to 0 (takes priority over advance)
//   advance    - increments the count by one, wrapping at NUM_SRC-1
//   count      - current scan index
module src_scan_counter
  import operand_select_pipe_pkg::*;
#(
  parameter  int unsigned NUM_SRC = DEFAULT_NUM_SRC,
  localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [SEL_W-1:0] count
);

  logic [SEL_W-1:0] r_count;

  // Wrap explicitly so a non-power-of-two source count never produces an out-of-range index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (advance) begin
      r_count <= (r_count == SEL_W'(NUM_SRC - 1)) ? '0 : r_count + SEL_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/operand_select_pipe.sv
// Operand select pipeline: picks one of NUM_SRC operands, either by an explicit index
// (direct mode) or by an internal scan counter (scan mode), and holds it in a single
// valid/ready output register stage.
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   src_data             - flattened sources, source i at [i*WIDTH +: WIDTH]
//   select, mode         - direct-mode index and mode (0 direct, 1 scan)
//   in_valid / in_ready  - capture request / capture allowed (combinational)
//   out_operand/src/err  - captured operand, its index, out-of-range flag
//   out_valid/out_ready  - output handshake
module operand_select_pipe
  import operand_select_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter  int unsigned NUM_SRC = DEFAULT_NUM_SRC,
  localparam int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         select,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_operand,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned CMP_W = SEL_W + 1;

  logic             r_valid;
  logic [WIDTH-1:0] r_operand;
  logic [SEL_W-1:0] r_src;
  logic             r_err;

  logic             w_capture;
  logic             w_scan;
  logic             w_err;
  logic [SEL_W-1:0] w_count;
  logic [SEL_W-1:0] w_idx;
  logic [WIDTH-1:0] w_operand;

  // The stage accepts new data when empty or when its current contents drain this cycle.
  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready;
  assign w_scan    = (mode == MODE_SCAN);
  assign w_idx     = w_scan ? w_count : select;
  assign w_err     = {1'b0, w_idx} >= CMP_W'(NUM_SRC);

  // The counter is held at 0 outside scan mode so every scan run starts at source 0.
  src_scan_counter #(
    .NUM_SRC (NUM_SRC)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_scan),
    .advance (w_capture && w_scan),
    .count   (w_count)
  );

  // Source mux; an index with no matching source yields 0.
  always_comb begin
    w_operand = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_idx == SEL_W'(i)) begin
        w_operand = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Single output stage: load on capture, otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_operand <= '0;
      r_src     <= '0;
      r_err     <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_operand <= w_operand;
      r_src     <= w_idx;
      r_err     <= w_err;
    end else if (r_valid && out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_operand = r_operand;
  assign out_src     = r_src;
  assign out_err     = r_err;

endmodule
